// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned MUL/DIVU/REMU sequencer that borrows the shared ALU for every add/subtract
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start, op, a, b    request (sampled only in IDLE); op 00 MUL, 01 DIVU, 10 REMU, 11 reserved
//   busy, done, result busy while RUN/DONE, one-cycle done pulse, registered result
//   alu_a, alu_b,      operands and op code driven to the shared ALU (idle: 0, 0, ALU_ADD)
//   alu_op, alu_result combinational ALU result returned in the same cycle
module muldiv_seq #(
    parameter int          XLEN    = 32,
    parameter logic [3:0]  ALU_ADD = 4'b0000,
    parameter logic [3:0]  ALU_SUB = 4'b0001
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    // acc: MUL accumulator / division remainder
    // bop: shifting multiplicand / divisor
    // q:   multiplier (shifted right) / quotient (shifted left)
    logic [XLEN-1:0] acc, bop, q, acc_nx, bop_nx, q_nx, result_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [1:0]      op_q, op_q_nx;
    logic [XLEN:0]   s;
    logic            ge;

    // Restoring division step: shift the next dividend bit into the partial remainder
    // and compare at 33 bits so divisors above 2^31 are handled correctly.
    assign s    = {acc, q[XLEN-1]};
    assign ge   = s >= {1'b0, bop};
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        bop_nx    = bop;
        q_nx      = q;
        cnt_nx    = cnt;
        op_q_nx   = op_q;
        result_nx = result;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD;
        case (state)
            IDLE: begin
                if (start) begin
                    op_q_nx = op;
                    if (op == 2'b11) begin
                        state_nx  = DONE;
                        result_nx = '0;
                    end else if (op != 2'b00 && b == '0) begin
                        state_nx  = DONE;
                        result_nx = op == 2'b01 ? '1 : a;
                    end else begin
                        state_nx = RUN;
                        acc_nx   = '0;
                        bop_nx   = b;
                        q_nx     = a;
                        cnt_nx   = '0;
                    end
                end
            end
            RUN: begin
                if (op_q == 2'b00) begin
                    alu_a  = acc;
                    alu_b  = bop;
                    acc_nx = q[0] ? alu_result : acc;
                    bop_nx = bop << 1;
                    q_nx   = q >> 1;
                end else begin
                    alu_a  = s[XLEN-1:0];
                    alu_b  = bop;
                    alu_op = ALU_SUB;
                    acc_nx = ge ? alu_result : s[XLEN-1:0];
                    q_nx   = {q[XLEN-2:0], ge};
                end
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(XLEN - 1)) begin
                    state_nx  = DONE;
                    result_nx = op_q == 2'b01 ? q_nx : acc_nx;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            acc    <= '0;
            bop    <= '0;
            q      <= '0;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            bop    <= bop_nx;
            q      <= q_nx;
            cnt    <= cnt_nx;
            op_q   <= op_q_nx;
            result <= result_nx;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq with a behavioural shared ALU
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rstn, start, busy, done;
    logic [1:0]  op;
    logic [31:0] a, b, result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    int          n_chk = 0, n_fail = 0, cyc = 0, st_cyc = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] e;
    int          l;

    muldiv_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    assign alu_result = alu_op == 4'b0001 ? alu_a - alu_b : alu_a + alu_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h expected no done pulse", result);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                chk("result", result, e);
                chk("latency", 32'(cyc - st_cyc), 32'(l));
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input int lat);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(r);
        lat_q.push_back(lat);
        @(posedge clk);
        #1;
        st_cyc = cyc;
        start  = 1'b0;
    endtask

    task automatic track(input logic [1:0] o, input int lat, input bit poke, input bit chain,
                         input logic [1:0] co, input logic [31:0] ca, input logic [31:0] cb);
        int nb = 0;
        bit fin = 0;
        for (int n = 0; n < 100 && !fin; n++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                if (!done) chk("alu_op_run", {28'd0, alu_op}, o == 2'b00 ? 32'd0 : 32'd1);
                if (poke) begin
                    op = 2'b01; a = 32'd1; b = 32'd1;
                    start = (nb == 5 || nb == 10);
                end
                if (chain && done) begin
                    op = co; a = ca; b = cb; start = 1'b1;
                end
            end else begin
                fin = 1;
                chk("alu_a_idle", alu_a, 32'd0);
                chk("alu_op_idle", {28'd0, alu_op}, 32'd0);
            end
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: busy still high after 100 cycles, expected idle");
        end
        chk("busy_cycles", 32'(nb), 32'(lat + 1));
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_done: got no done pulse, expected result %h", exp_q[0]);
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input int lat);
        launch(o, x, y, r, lat);
        track(o, lat, 0, 0, 2'b00, 32'd0, 32'd0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run(2'b00, 32'd7, 32'd6, 32'd42, 32);
        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
        run(2'b00, 32'd0, 32'h12345678, 32'd0, 32);
        run(2'b00, 32'h00010000, 32'h00010000, 32'd0, 32);
        run(2'b01, 32'd100, 32'd7, 32'd14, 32);
        run(2'b10, 32'd100, 32'd7, 32'd2, 32);
        run(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32);
        run(2'b01, 32'd7, 32'd100, 32'd0, 32);
        run(2'b10, 32'd7, 32'd100, 32'd7, 32);
        run(2'b01, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32);
        run(2'b10, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32);
        run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32);
        run(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32);
        run(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        run(2'b10, 32'd5, 32'd0, 32'd5, 0);
        run(2'b11, 32'd9, 32'd3, 32'd0, 0);

        // start pulses during RUN must be ignored
        launch(2'b00, 32'd7, 32'd6, 32'd42, 32);
        track(2'b00, 32, 1, 0, 2'b00, 32'd0, 32'd0);
        start = 1'b0;

        // start raised on the DONE cycle is taken only once back in IDLE
        launch(2'b00, 32'd3, 32'd4, 32'd12, 32);
        track(2'b00, 32, 0, 1, 2'b01, 32'd100, 32'd7);
        launch(2'b01, 32'd100, 32'd7, 32'd14, 32);
        track(2'b01, 32, 0, 0, 2'b00, 32'd0, 32'd0);

        // reset in the middle of a run aborts without a done pulse
        op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        run(2'b10, 32'd100, 32'd7, 32'd2, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
